alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops, plus iterative shift-add multiply
// and restoring divide, both with a valid/ready handshake on the input and output sides.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [4:0]            ALUop,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] ResultHi,
  output logic                  Zero,
  output logic                  Overflow,
  output logic                  CarryOut
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [4:0] OP_AND  = 5'd0,  OP_OR   = 5'd1,  OP_ADD  = 5'd2,  OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SAL  = 5'd8,  OP_SRA  = 5'd9,  OP_LUI  = 5'd10, OP_XOR  = 5'd11;
  localparam logic [4:0] OP_NOR  = 5'd12, OP_MULT = 5'd13, OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15, OP_DIVU = 5'd16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     result_reg, result_next;
  logic [W-1:0]     result_hi_reg, result_hi_next;
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;
  logic             carry_reg, carry_next;
  logic [W-1:0]     acc_reg, acc_next;       // product high half / partial remainder
  logic [W-1:0]     q_reg, q_next;           // multiplier bits / dividend-then-quotient
  logic [W-1:0]     mag_b_reg, mag_b_next;   // multiplicand or divisor magnitude
  logic [W-1:0]     a_orig_reg, a_orig_next;
  logic             is_div_reg, is_div_next;
  logic             neg_a_reg, neg_a_next;
  logic             neg_b_reg, neg_b_next;
  logic             div_zero_reg, div_zero_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign out_valid = (state_reg == DONE);
  assign Result    = result_reg;
  assign ResultHi  = result_hi_reg;
  assign Zero      = zero_reg;
  assign Overflow  = ovf_reg;
  assign CarryOut  = carry_reg;

  // Single-cycle datapath, evaluated straight from the request inputs.
  logic [W:0]         add_full, sub_full;
  logic               add_ovf, sub_ovf;
  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       sc_res;
  logic               sc_zero, sc_ovf, sc_carry;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
  assign add_ovf  = (A[W-1] == B[W-1]) && (add_full[W-1] != A[W-1]);
  assign sub_ovf  = (A[W-1] != B[W-1]) && (sub_full[W-1] != A[W-1]);
  assign shamt    = A[SHAMT_W-1:0];

  always_comb begin
    sc_res   = '0;
    sc_zero  = 1'b0;
    sc_ovf   = 1'b0;
    sc_carry = 1'b0;
    case (ALUop)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_ADD:  begin sc_res = add_full[W-1:0]; sc_ovf = add_ovf; sc_carry = add_full[W]; end
      OP_SUB:  begin sc_res = sub_full[W-1:0]; sc_ovf = sub_ovf; sc_carry = sub_full[W]; end
      OP_SLT:  sc_res = {{(W-1){1'b0}}, sub_full[W-1] ^ sub_ovf};
      OP_SLTU: sc_res = {{(W-1){1'b0}}, ~sub_full[W]};
      OP_SLL, OP_SAL: sc_res = B << shamt;
      OP_SRL:  sc_res = B >> shamt;
      OP_SRA:  sc_res = $signed(B) >>> shamt;
      OP_LUI:  sc_res = {B[W/2-1:0], {(W/2){1'b0}}};
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      default: sc_res = '0;
    endcase
    if ((ALUop == OP_AND) || (ALUop == OP_OR) || (ALUop == OP_ADD) ||
        (ALUop == OP_SUB) || (ALUop == OP_XOR) || (ALUop == OP_NOR))
      sc_zero = (sc_res == '0);
  end

  // Operand setup for the iterative unit: signed ops work on magnitudes.
  logic         op_iter, op_signed, op_div;
  logic [W-1:0] abs_a, abs_b;

  assign op_iter   = (ALUop >= OP_MULT) && (ALUop <= OP_DIVU);
  assign op_signed = (ALUop == OP_MULT) || (ALUop == OP_DIV);
  assign op_div    = (ALUop == OP_DIV) || (ALUop == OP_DIVU);
  assign abs_a     = (op_signed && A[W-1]) ? -A : A;
  assign abs_b     = (op_signed && B[W-1]) ? -B : B;

  // One bit per cycle: shift-add multiply (LSB first) or restoring divide (MSB first).
  logic [W:0]     mul_sum, div_shift, div_trial;
  logic           div_ok;
  logic [W-1:0]   step_acc, step_q;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fin_lo, fin_hi;

  assign mul_sum   = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, mag_b_reg} : {(W+1){1'b0}});
  assign div_shift = {acc_reg, q_reg[W-1]};
  assign div_trial = div_shift - {1'b0, mag_b_reg};
  assign div_ok    = ~div_trial[W];
  assign step_acc  = is_div_reg ? (div_ok ? div_trial[W-1:0] : div_shift[W-1:0]) : mul_sum[W:1];
  assign step_q    = is_div_reg ? {q_reg[W-2:0], div_ok} : {mul_sum[0], q_reg[W-1:1]};

  assign prod     = {step_acc, step_q};
  assign prod_fix = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
  assign quo_fix  = (neg_a_reg ^ neg_b_reg) ? -step_q : step_q;
  assign rem_fix  = neg_a_reg ? -step_acc : step_acc;
  assign fin_lo   = is_div_reg ? (div_zero_reg ? {W{1'b1}} : quo_fix) : prod_fix[W-1:0];
  assign fin_hi   = is_div_reg ? (div_zero_reg ? a_orig_reg : rem_fix) : prod_fix[2*W-1:W];

  always_comb begin
    state_next     = state_reg;
    result_next    = result_reg;
    result_hi_next = result_hi_reg;
    zero_next      = zero_reg;
    ovf_next       = ovf_reg;
    carry_next     = carry_reg;
    acc_next       = acc_reg;
    q_next         = q_reg;
    mag_b_next     = mag_b_reg;
    a_orig_next    = a_orig_reg;
    is_div_next    = is_div_reg;
    neg_a_next     = neg_a_reg;
    neg_b_next     = neg_b_reg;
    div_zero_next  = div_zero_reg;
    cnt_next       = cnt_reg;

    case (state_reg)
      IDLE: ;
      BUSY: begin
        acc_next = step_acc;
        q_next   = step_q;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(W-1)) begin
          state_next     = DONE;
          result_next    = fin_lo;
          result_hi_next = fin_hi;
          zero_next      = 1'b0;
          ovf_next       = 1'b0;
          carry_next     = 1'b0;
          cnt_next       = '0;
        end
      end
      DONE: if (out_ready && !in_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (in_valid && in_ready) begin
      if (op_iter) begin
        state_next    = BUSY;
        cnt_next      = '0;
        is_div_next   = op_div;
        neg_a_next    = op_signed && A[W-1];
        neg_b_next    = op_signed && B[W-1];
        div_zero_next = (B == '0);
        a_orig_next   = A;
        acc_next      = '0;
        q_next        = op_div ? abs_a : abs_b;
        mag_b_next    = op_div ? abs_b : abs_a;
      end else begin
        state_next     = DONE;
        result_next    = sc_res;
        result_hi_next = '0;
        zero_next      = sc_zero;
        ovf_next       = sc_ovf;
        carry_next     = sc_carry;
      end
    end

    // Flush overrides any transfer decided above.
    if (flush) begin
      state_next     = IDLE;
      cnt_next       = '0;
      result_next    = '0;
      result_hi_next = '0;
      zero_next      = 1'b0;
      ovf_next       = 1'b0;
      carry_next     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      acc_reg       <= '0;
      q_reg         <= '0;
      mag_b_reg     <= '0;
      a_orig_reg    <= '0;
      is_div_reg    <= 1'b0;
      neg_a_reg     <= 1'b0;
      neg_b_reg     <= 1'b0;
      div_zero_reg  <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      result_reg    <= result_next;
      result_hi_reg <= result_hi_next;
      zero_reg      <= zero_next;
      ovf_reg       <= ovf_next;
      carry_reg     <= carry_next;
      acc_reg       <= acc_next;
      q_reg         <= q_next;
      mag_b_reg     <= mag_b_next;
      a_orig_reg    <= a_orig_next;
      is_div_reg    <= is_div_next;
      neg_a_reg     <= neg_a_next;
      neg_b_reg     <= neg_b_next;
      div_zero_reg  <= div_zero_next;
      cnt_reg       <= cnt_next;
    end
  end

endmodule
